pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Consumer end of the pc_mux_select interface: owns the program counter and the IF half of the two-stage pipeline.
//  Each cycle it selects the next PC from select, branch/jump/jalr targets and sequential PC+4.
//  It issues instruction-memory requests and presents the fetched instruction to EXE via the IF/EXE register.
//  It also flushes wrong-path fetches on redirect.
// PARAMETERS
//  XLEN      32            datapath/address width
//  RESET_PC  32'h0000_0000 first fetch address after reset
//  TRAP_VEC  32'h0000_0100 misalign trap target (used only with PC_MISALIGN_TRAP_EN)
// PORTS
//  clk            in   1     single clock, rising edge
//  rst            in   1     synchronous, active-high reset
//  pc_mux_select  in   2     00 seq, 01 branch, 10 jump, 11 jalr (from EXE)
//  branch_target  in   XLEN  branch target from EXE
//  jump_target    in   XLEN  jal target from EXE
//  jalr_target    in   XLEN  rs1+imm from EXE (bit0 cleared here)
//  stall          in   1     EXE cannot accept a new instruction this cycle
//  imem_req       out  1     fetch request valid
//  imem_addr      out  XLEN  fetch address, stable while imem_req && !imem_ready
//  imem_ready     in   1     response valid this cycle (>=0 wait states)
//  imem_rdata     in   32    instruction word, valid with imem_ready
//  if_valid       out  1     IF/EXE register holds a live instruction
//  if_instr       out  32    IF/EXE instruction
//  if_pc          out  XLEN  PC of if_instr
//  pc_misalign    out  1     one-cycle pulse on misaligned redirect (macro only)
// BEHAVIOUR
//  Reset (rst=1 at edge):
//   pc=RESET_PC; imem_req=0; if_valid=0; if_instr=32'h0000_0013 (NOP); if_pc=0; skid empty; state=S_IDLE.
//  FSM: S_IDLE -> S_FETCH after one cycle. S_FETCH -> S_DRAIN on a redirect while a request is unacknowledged.
//   S_DRAIN -> S_FETCH on imem_ready; that response is discarded.
//  Launch:
//   - In S_FETCH, launch when no request pending, skid empty, and !(stall && if_valid).
//   - At launch, imem_addr latches pc; imem_req stays high with a frozen address until imem_ready.
//  Response (S_FETCH):
//   - If EXE can accept (!stall || !if_valid), load if_instr/if_pc and set if_valid=1.
//   - Otherwise capture the response in a 1-entry skid buffer.
//   - Either way pc <= pc+4, modulo 2^XLEN (wrap at all-ones).
//  Consume: when if_valid && !stall and no new word arrives, clear if_valid next cycle.
//   Skid contents move to IF/EXE the first cycle stall=0.
//  Redirect (pc_mux_select!=0) beats stall, response and skid in the same cycle:
//   - pc <= selected target; jalr target uses {tgt[XLEN-1:1],1'b0}.
//   - Next cycle if_valid=0 and skid emptied.
//   - A response arriving in the redirect cycle is discarded.
//  Latency: with a zero-wait-state imem, redirect at edge N gives imem_req for the target at cycle N+1.
//   The target instruction is in IF/EXE at edge N+2.
//  Reset mid-transaction: outstanding request abandoned; the late imem_ready after reset is ignored (S_IDLE).
//  pc_mux_select is sampled only when the EXE instruction is live; gating is the caller's job.
// CONFIGURATION
//  PC_MISALIGN_TRAP_EN defined:
//   - A redirect target with bits[1:0]!=0 (after jalr bit0 clear) sets pc=TRAP_VEC.
//   - It also pulses pc_misalign for one cycle.
//  Undefined: target used as is (bits[1:0] passed through); pc_misalign tied 0.
// STRUCTURE
//  Shared package pkg_rv_pipe:
//   - PC_SEL_SEQ/BR/JAL/JALR encodings.
//   - NOP_INSTR=32'h0000_0013.
//   - FSM state typedef {S_IDLE,S_FETCH,S_DRAIN}.
//  One sub-module: pc_next_sel (combinational target mux, jalr LSB clear, misalign check).
//  Skid buffer and IF/EXE register stay in the top.
// TESTING
//  1 Reset, imem_ready=1 always, select=00:
//    addresses 0x0,0x4,0x8; if_pc trails by one cycle; if_valid=1 from cycle 2.
//  2 Branch: select=01, branch_target=0x40 at edge N.
//    Next imem_addr=0x40; if_valid=0 at N+1; if_pc=0x40 at N+2.
//  3 jalr_target=0x81 -> fetch at 0x80.
//    With PC_MISALIGN_TRAP_EN and jump_target=0x82: pc=TRAP_VEC and pc_misalign=1 for one cycle.
//  4 Hold imem_ready=0 for 3 cycles, redirect to 0x200 on cycle 1.
//    imem_addr stays old until ready; response discarded; next request addr=0x200.
//  5 stall=1 with if_valid=1 while a response arrives: skid holds it, no new request.
//    On stall=0 if_instr updates, then fetching resumes; no instruction lost or duplicated.
//  6 pc=32'hFFFF_FFFC sequential: next fetch 0x0.
//    rst asserted mid-wait: imem_req=0 next cycle, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package   : pkg_rv_pipe
// Purpose   : Shared encodings for the two-stage fetch/execute pipeline:
//             next-PC select codes, NOP instruction, fetch FSM states.
// Revision  : 1.0 - initial release
// ============================================================================
package pkg_rv_pipe;

   localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
   localparam logic [1:0] PC_SEL_BR   = 2'b01;
   localparam logic [1:0] PC_SEL_JAL  = 2'b10;
   localparam logic [1:0] PC_SEL_JALR = 2'b11;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   // Any non-sequential select redirects the fetch stream.
   function automatic logic is_redirect(input logic [1:0] sel);
      return (sel != PC_SEL_SEQ);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_unit_pc_next_sel.sv
`default_nettype none
// ============================================================================
// Module    : pc_next_sel
// Purpose   : Combinational redirect-target mux. Clears the jalr LSB and, when
//             PC_MISALIGN_TRAP_EN is defined, replaces a misaligned target
//             with TRAP_VEC and flags it.
// Revision  : 1.0 - initial release
// ============================================================================
module pc_next_sel
   import pkg_rv_pipe::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic [1:0]      pc_mux_select,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jump_target,
   input  logic [XLEN-1:0] jalr_target,
   output logic            redirect,
   output logic [XLEN-1:0] target,
   output logic            misalign
);

`ifdef PC_MISALIGN_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   logic [XLEN-1:0] raw_target;
   logic            raw_misalign;

   // Select the raw redirect target and test its word alignment.
   always_comb begin
      raw_target = '0;
      case (pc_mux_select)
         PC_SEL_BR:   raw_target = branch_target;
         PC_SEL_JAL:  raw_target = jump_target;
         PC_SEL_JALR: raw_target = jalr_target & ~XLEN'(1);
         default:     raw_target = '0;
      endcase
      redirect     = is_redirect(pc_mux_select);
      raw_misalign = redirect && (raw_target[1:0] != 2'b00);
      misalign     = TRAP_EN && raw_misalign;
      target       = misalign ? TRAP_VEC : raw_target;
   end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module    : pc_fetch_unit
// Purpose   : Program counter and IF stage. Issues instruction-memory requests,
//             holds the IF/EXE register plus a one-entry skid buffer, and
//             flushes wrong-path fetches on redirect.
// Config    : PC_MISALIGN_TRAP_EN - misaligned redirect traps to TRAP_VEC and
//             pulses pc_misalign; otherwise targets pass through unchanged.
// Revision  : 1.0 - initial release
// ============================================================================
module pc_fetch_unit
   import pkg_rv_pipe::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      pc_mux_select,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jump_target,
   input  logic [XLEN-1:0] jalr_target,
   input  logic            stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [31:0]     imem_rdata,
   output logic            if_valid,
   output logic [31:0]     if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic            pc_misalign
);

   state_e          state, state_nxt;
   logic [XLEN-1:0] pc, pc_nxt;
   logic            req_nxt;
   logic [XLEN-1:0] addr_nxt;
   logic            ifv_nxt;
   logic [31:0]     ifi_nxt;
   logic [XLEN-1:0] ifp_nxt;
   logic            skid_valid, skv_nxt;
   logic [31:0]     skid_instr, ski_nxt;
   logic [XLEN-1:0] skid_pc, skp_nxt;
   logic            mis_nxt;

   logic            redirect;
   logic [XLEN-1:0] target;
   logic            misalign;
   logic            resp;
   logic            accept;
   logic [XLEN-1:0] pc_inc;

   pc_next_sel #(
      .XLEN     (XLEN),
      .TRAP_VEC (TRAP_VEC)
   ) u_pc_next_sel (
      .pc_mux_select (pc_mux_select),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .jalr_target   (jalr_target),
      .redirect      (redirect),
      .target        (target),
      .misalign      (misalign)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state and datapath decode; redirect outranks response, stall and skid.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      req_nxt   = imem_req;
      addr_nxt  = imem_addr;
      ifv_nxt   = if_valid;
      ifi_nxt   = if_instr;
      ifp_nxt   = if_pc;
      skv_nxt   = skid_valid;
      ski_nxt   = skid_instr;
      skp_nxt   = skid_pc;
      mis_nxt   = 1'b0;
      resp      = imem_req && imem_ready;
      accept    = !stall || !if_valid;
      pc_inc    = pc + XLEN'(4);

      case (state)
         S_IDLE: begin
            state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (redirect) begin
               pc_nxt  = target;
               ifv_nxt = 1'b0;
               skv_nxt = 1'b0;
               mis_nxt = misalign;
               if (imem_req && !imem_ready) begin
                  // Wrong-path request still outstanding: wait it out.
                  state_nxt = S_DRAIN;
               end else begin
                  req_nxt  = 1'b1;
                  addr_nxt = target;
               end
            end else if (resp) begin
               pc_nxt = pc_inc;
               if (accept) begin
                  ifv_nxt  = 1'b1;
                  ifi_nxt  = imem_rdata;
                  ifp_nxt  = imem_addr;
                  req_nxt  = 1'b1;
                  addr_nxt = pc_inc;
               end else begin
                  skv_nxt = 1'b1;
                  ski_nxt = imem_rdata;
                  skp_nxt = imem_addr;
                  req_nxt = 1'b0;
               end
            end else begin
               if (if_valid && !stall) begin
                  if (skid_valid) begin
                     ifi_nxt = skid_instr;
                     ifp_nxt = skid_pc;
                     skv_nxt = 1'b0;
                  end else begin
                     ifv_nxt = 1'b0;
                  end
               end
               if (!imem_req && !skid_valid && !(stall && if_valid)) begin
                  req_nxt  = 1'b1;
                  addr_nxt = pc;
               end
            end
         end
         S_DRAIN: begin
            if (redirect) begin
               pc_nxt  = target;
               ifv_nxt = 1'b0;
               skv_nxt = 1'b0;
               mis_nxt = misalign;
            end
            if (imem_ready) begin
               // Stale response is dropped; relaunch from pc next cycle.
               req_nxt   = 1'b0;
               state_nxt = S_FETCH;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // PC, request, IF/EXE register and skid buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         imem_req    <= 1'b0;
         imem_addr   <= RESET_PC;
         if_valid    <= 1'b0;
         if_instr    <= NOP_INSTR;
         if_pc       <= '0;
         skid_valid  <= 1'b0;
         skid_instr  <= NOP_INSTR;
         skid_pc     <= '0;
         pc_misalign <= 1'b0;
      end else begin
         pc          <= pc_nxt;
         imem_req    <= req_nxt;
         imem_addr   <= addr_nxt;
         if_valid    <= ifv_nxt;
         if_instr    <= ifi_nxt;
         if_pc       <= ifp_nxt;
         skid_valid  <= skv_nxt;
         skid_instr  <= ski_nxt;
         skid_pc     <= skp_nxt;
         pc_misalign <= mis_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module    : tb_pc_fetch_unit
// Purpose   : Directed self-checking bench for pc_fetch_unit. Instruction
//             memory returns the bitwise inverse of the request address.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_unit;

   logic        clk;
   logic        rst;
   logic [1:0]  pc_mux_select;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] jalr_target;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        pc_misalign;

   int checks   = 0;
   int failures = 0;

   logic [31:0] trap_pc;
   logic        trap_pulse;
   logic [31:0] old_addr;

   pc_fetch_unit #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0000),
      .TRAP_VEC (32'h0000_0100)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_mux_select (pc_mux_select),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .jalr_target   (jalr_target),
      .stall         (stall),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rdata    (imem_rdata),
      .if_valid      (if_valid),
      .if_instr      (if_instr),
      .if_pc         (if_pc),
      .pc_misalign   (pc_misalign)
   );

   assign imem_rdata = ~imem_addr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
`ifdef PC_MISALIGN_TRAP_EN
      trap_pc    = 32'h0000_0100;
      trap_pulse = 1'b1;
`else
      trap_pc    = 32'h0000_0082;
      trap_pulse = 1'b0;
`endif
      rst = 1'b1; pc_mux_select = 2'b00; stall = 1'b0; imem_ready = 1'b1;
      branch_target = '0; jump_target = '0; jalr_target = '0;

      // Reset state
      tick();
      check("rst_req",    {31'd0, imem_req}, 32'd0);
      check("rst_ifv",    {31'd0, if_valid}, 32'd0);
      check("rst_instr",  if_instr, 32'h0000_0013);
      check("rst_ifpc",   if_pc, 32'd0);
      check("rst_mis",    {31'd0, pc_misalign}, 32'd0);

      // Sequential fetch, zero wait states
      rst = 1'b0;
      tick();
      check("idle_req",   {31'd0, imem_req}, 32'd0);
      tick();
      check("seq0_req",   {31'd0, imem_req}, 32'd1);
      check("seq0_addr",  imem_addr, 32'h0);
      check("seq0_ifv",   {31'd0, if_valid}, 32'd0);
      tick();
      check("seq1_addr",  imem_addr, 32'h4);
      check("seq1_ifv",   {31'd0, if_valid}, 32'd1);
      check("seq1_ifpc",  if_pc, 32'h0);
      check("seq1_instr", if_instr, ~32'h0);
      tick();
      check("seq2_addr",  imem_addr, 32'h8);
      check("seq2_ifpc",  if_pc, 32'h4);
      tick();
      check("seq3_ifpc",  if_pc, 32'h8);

      // Branch redirect
      pc_mux_select = 2'b01; branch_target = 32'h40;
      tick();
      check("br_addr",    imem_addr, 32'h40);
      check("br_ifv",     {31'd0, if_valid}, 32'd0);
      pc_mux_select = 2'b00;
      tick();
      check("br_ifpc",    if_pc, 32'h40);
      check("br_instr",   if_instr, ~32'h40);
      check("br_next",    imem_addr, 32'h44);

      // jalr LSB clear
      pc_mux_select = 2'b11; jalr_target = 32'h81;
      tick();
      check("jalr_addr",  imem_addr, 32'h80);
      check("jalr_mis",   {31'd0, pc_misalign}, 32'd0);
      pc_mux_select = 2'b00;
      tick();
      check("jalr_ifpc",  if_pc, 32'h80);

      // Misaligned jal target
      pc_mux_select = 2'b10; jump_target = 32'h82;
      tick();
      check("mis_addr",   imem_addr, trap_pc);
      check("mis_pulse",  {31'd0, pc_misalign}, {31'd0, trap_pulse});
      pc_mux_select = 2'b00;
      tick();
      check("mis_clear",  {31'd0, pc_misalign}, 32'd0);
      check("mis_ifpc",   if_pc, trap_pc);
      old_addr = trap_pc + 32'd4;
      check("mis_next",   imem_addr, old_addr);

      // Wait states with redirect while a request is outstanding
      imem_ready = 1'b0;
      tick();
      check("ws1_addr",   imem_addr, old_addr);
      check("ws1_ifv",    {31'd0, if_valid}, 32'd0);
      pc_mux_select = 2'b01; branch_target = 32'h200;
      tick();
      check("ws2_addr",   imem_addr, old_addr);
      check("ws2_req",    {31'd0, imem_req}, 32'd1);
      pc_mux_select = 2'b00;
      tick();
      check("ws3_addr",   imem_addr, old_addr);
      imem_ready = 1'b1;
      tick();
      check("drain_ifv",  {31'd0, if_valid}, 32'd0);
      check("drain_req",  {31'd0, imem_req}, 32'd0);
      tick();
      check("relaunch",   imem_addr, 32'h200);
      check("relaunch_r", {31'd0, imem_req}, 32'd1);
      tick();
      check("ws_ifpc",    if_pc, 32'h200);
      check("ws_instr",   if_instr, ~32'h200);

      // Stall with a response in flight: skid buffer
      stall = 1'b1;
      tick();
      check("skid_ifpc",  if_pc, 32'h200);
      check("skid_req",   {31'd0, imem_req}, 32'd0);
      tick();
      check("skid_hold",  {31'd0, imem_req}, 32'd0);
      check("skid_ifpc2", if_pc, 32'h200);
      stall = 1'b0;
      tick();
      check("unskid_pc",  if_pc, 32'h204);
      check("unskid_ins", if_instr, ~32'h204);
      check("unskid_req", {31'd0, imem_req}, 32'd0);
      tick();
      check("resume_adr", imem_addr, 32'h208);
      check("resume_req", {31'd0, imem_req}, 32'd1);
      check("resume_ifv", {31'd0, if_valid}, 32'd0);
      tick();
      check("resume_pc",  if_pc, 32'h208);
      check("resume_v",   {31'd0, if_valid}, 32'd1);

      // PC wrap at the top of the address space
      pc_mux_select = 2'b10; jump_target = 32'hFFFF_FFFC;
      tick();
      check("top_addr",   imem_addr, 32'hFFFF_FFFC);
      pc_mux_select = 2'b00;
      tick();
      check("top_ifpc",   if_pc, 32'hFFFF_FFFC);
      check("wrap_addr",  imem_addr, 32'h0);

      // Reset in the middle of a wait
      imem_ready = 1'b0;
      tick();
      check("pre_rst_req", {31'd0, imem_req}, 32'd1);
      rst = 1'b1;
      tick();
      check("mrst_req",   {31'd0, imem_req}, 32'd0);
      check("mrst_ifv",   {31'd0, if_valid}, 32'd0);
      rst = 1'b0; imem_ready = 1'b1;
      tick();
      check("late_req",   {31'd0, imem_req}, 32'd0);
      check("late_ifv",   {31'd0, if_valid}, 32'd0);
      tick();
      check("restart_a",  imem_addr, 32'h0);
      check("restart_r",  {31'd0, imem_req}, 32'd1);
      tick();
      check("restart_pc", if_pc, 32'h0);
      check("restart_v",  {31'd0, if_valid}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
